// File: rtl/counter_pkg.sv
// Shared sizing and types for the 4-bit up/down counter and its command front end.
package counter_pkg;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 2;
    localparam int MAXV   = (1 << WIDTH) - 1;

    typedef logic [WIDTH-1:0]  cnt_t;
    typedef logic [STEP_W-1:0] step_t;

endpackage

// File: rtl/counter_bound_check.sv
// Combinational credit check: grants up/down requests only when the projected
// count stays inside 0..MAXV. A pending reload blocks both directions.
module counter_bound_check
    import counter_pkg::*;
#(
    parameter int WIDTH  = counter_pkg::WIDTH,
    parameter int STEP_W = counter_pkg::STEP_W
) (
    input  logic [WIDTH-1:0]  proj,
    input  logic [STEP_W-1:0] up_count,
    input  logic [STEP_W-1:0] dn_count,
    input  logic              dn_valid,
    input  logic              load_valid,
    output logic              up_ready,
    output logic              dn_ready
);

    localparam int W1      = WIDTH + 1;
    localparam int CNT_TOP = (1 << WIDTH) - 1;

    logic          dn_fire;
    logic [W1-1:0] up_sum;
    logic [W1-1:0] up_lim;

    // A same-cycle decrement frees headroom for the increment, hence the extra bit.
    always_comb begin
        dn_ready = !load_valid && ({1'b0, proj} >= W1'(dn_count));
        dn_fire  = dn_valid && dn_ready;
        up_sum   = {1'b0, proj} + W1'(up_count);
        up_lim   = W1'(CNT_TOP) + (dn_fire ? W1'(dn_count) : '0);
        up_ready = !load_valid && (up_sum <= up_lim);
    end

endmodule

// File: rtl/counter_cmd_packer.sv
// Packs load/up/down requests into one registered counter command per cycle,
// tracks the projected count and flags any disagreement with counter feedback.
module counter_cmd_packer
    import counter_pkg::*;
#(
    parameter int WIDTH  = counter_pkg::WIDTH,
    parameter int STEP_W = counter_pkg::STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_value,
    output logic              load_ready,
    input  logic              up_valid,
    input  logic [STEP_W-1:0] up_count,
    output logic              up_ready,
    input  logic              dn_valid,
    input  logic [STEP_W-1:0] dn_count,
    output logic              dn_ready,
    output logic              incr_valid,
    output logic [STEP_W-1:0] incr,
    output logic              decr_valid,
    output logic [STEP_W-1:0] decr,
    output logic              reinit,
    output logic [WIDTH-1:0]  initial_value,
    input  logic [WIDTH-1:0]  value,
    output logic [WIDTH-1:0]  proj,
    output logic              mismatch_err
);

    logic             load_fire;
    logic             up_fire;
    logic             dn_fire;
    logic [WIDTH-1:0] proj_d1;
    logic             arm_q1;
    logic             arm_q2;

    assign load_ready = 1'b1;
    assign load_fire  = load_valid & load_ready;
    assign up_fire    = up_valid & up_ready;
    assign dn_fire    = dn_valid & dn_ready;

    counter_bound_check #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_bound (
        .proj       (proj),
        .up_count   (up_count),
        .dn_count   (dn_count),
        .dn_valid   (dn_valid),
        .load_valid (load_valid),
        .up_ready   (up_ready),
        .dn_ready   (dn_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            incr_valid    <= 1'b0;
            incr          <= '0;
            decr_valid    <= 1'b0;
            decr          <= '0;
            reinit        <= 1'b0;
            initial_value <= '0;
            proj          <= '0;
        end else begin
            incr_valid    <= up_fire;
            incr          <= up_fire ? up_count : '0;
            decr_valid    <= dn_fire;
            decr          <= dn_fire ? dn_count : '0;
            reinit        <= load_fire;
            initial_value <= load_fire ? load_value : '0;
            if (load_fire)
                proj <= load_value;
            else
                proj <= proj + (up_fire ? WIDTH'(up_count) : '0)
                             - (dn_fire ? WIDTH'(dn_count) : '0);
        end
    end

    // Counter feedback lags proj by one edge; checking starts once both sides are post-load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proj_d1      <= '0;
            arm_q1       <= 1'b0;
            arm_q2       <= 1'b0;
            mismatch_err <= 1'b0;
        end else begin
            proj_d1      <= proj;
            arm_q1       <= arm_q1 | load_fire;
            arm_q2       <= arm_q1;
            mismatch_err <= mismatch_err | (arm_q2 && (value != proj_d1));
        end
    end

endmodule

// File: tb/tb_counter_cmd_packer.sv
// Bench for counter_cmd_packer: directed scenarios plus randomized producers,
// checked against an integer projection model and a behavioural counter stand-in.
module tb_counter_cmd_packer;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 2;
    localparam int MAXV   = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid;
    logic [WIDTH-1:0]  load_value;
    logic              load_ready;
    logic              up_valid;
    logic [STEP_W-1:0] up_count;
    logic              up_ready;
    logic              dn_valid;
    logic [STEP_W-1:0] dn_count;
    logic              dn_ready;
    logic              incr_valid;
    logic [STEP_W-1:0] incr;
    logic              decr_valid;
    logic [STEP_W-1:0] decr;
    logic              reinit;
    logic [WIDTH-1:0]  initial_value;
    logic [WIDTH-1:0]  value;
    logic [WIDTH-1:0]  proj;
    logic              mismatch_err;

    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  corrupt;

    int checks   = 0;
    int failures = 0;
    int m_proj   = 0;
    bit exp_err  = 0;
    bit g_uf     = 0;
    bit g_df     = 0;

    always #5 clk = ~clk;

    counter_cmd_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_value    (load_value),
        .load_ready    (load_ready),
        .up_valid      (up_valid),
        .up_count      (up_count),
        .up_ready      (up_ready),
        .dn_valid      (dn_valid),
        .dn_count      (dn_count),
        .dn_ready      (dn_ready),
        .incr_valid    (incr_valid),
        .incr          (incr),
        .decr_valid    (decr_valid),
        .decr          (decr),
        .reinit        (reinit),
        .initial_value (initial_value),
        .value         (value),
        .proj          (proj),
        .mismatch_err  (mismatch_err)
    );

    // Downstream counter stand-in; corrupt lets a test inject bad feedback.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (reinit)
            cnt <= initial_value;
        else
            cnt <= 4'(int'(cnt) + (incr_valid ? int'(incr) : 0) - (decr_valid ? int'(decr) : 0));
    end
    assign value = cnt ^ corrupt;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called just after an edge with inputs already driven; runs one clock.
    task automatic step();
        bit dr, df, ur, uf, lf;
        int uc, dc, lv;
        #1;
        uc = int'(up_count);
        dc = int'(dn_count);
        lv = int'(load_value);
        lf = load_valid;
        dr = !load_valid && (m_proj >= dc);
        df = dn_valid && dr;
        ur = !load_valid && (m_proj + uc <= MAXV + (df ? dc : 0));
        uf = up_valid && ur;
        chk("load_ready", int'(load_ready), 1);
        chk("dn_ready", int'(dn_ready), int'(dr));
        chk("up_ready", int'(up_ready), int'(ur));
        @(posedge clk);
        #1;
        if (lf) m_proj = lv;
        else    m_proj = m_proj + (uf ? uc : 0) - (df ? dc : 0);
        chk("proj", int'(proj), m_proj);
        chk("incr_valid", int'(incr_valid), int'(uf));
        chk("incr", int'(incr), uf ? uc : 0);
        chk("decr_valid", int'(decr_valid), int'(df));
        chk("decr", int'(decr), df ? dc : 0);
        chk("reinit", int'(reinit), int'(lf));
        chk("initial_value", int'(initial_value), lf ? lv : 0);
        chk("mismatch_err", int'(mismatch_err), int'(exp_err));
        g_uf = uf;
        g_df = df;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_value = '0;
        up_valid   = 1'b0;
        up_count   = '0;
        dn_valid   = 1'b0;
        dn_count   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        corrupt = '0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        m_proj  = 0;
        exp_err = 0;
        chk("rst_proj", int'(proj), 0);
        chk("rst_cmd", int'({incr_valid, incr, decr_valid, decr, reinit, initial_value}), 0);
        chk("rst_err", int'(mismatch_err), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Load 5 then idle: counter follows, no error.
        load_valid = 1'b1; load_value = 4'd5;
        step();
        idle_inputs();
        step();
        chk("value_after_load", int'(value), 5);
        step();

        // Increment stalls at 14, then rides on a same-cycle decrement.
        load_valid = 1'b1; load_value = 4'd14;
        step();
        idle_inputs();
        up_valid = 1'b1; up_count = 2'd3;
        step();
        chk("up_stalls", int'(g_uf), 0);
        dn_valid = 1'b1; dn_count = 2'd2;
        step();
        chk("both_fire_proj", int'(proj), 15);
        idle_inputs();
        step();

        // Decrement stalls at 1 until an increment makes room.
        load_valid = 1'b1; load_value = 4'd1;
        step();
        idle_inputs();
        dn_valid = 1'b1; dn_count = 2'd2;
        up_valid = 1'b1; up_count = 2'd1;
        step();
        chk("dn_stalled", int'(g_df), 0);
        up_valid = 1'b0;
        step();
        chk("dn_drains_to_zero", int'(proj), 0);
        idle_inputs();

        // Reload excludes both directions.
        load_valid = 1'b1; load_value = 4'd9;
        up_valid = 1'b1; up_count = 2'd1;
        dn_valid = 1'b1; dn_count = 2'd1;
        step();
        idle_inputs();
        step();

        // Randomized producers that hold requests until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!up_valid || g_uf) begin
                up_valid = ($urandom_range(0, 2) != 0);
                up_count = 2'($urandom_range(0, 3));
            end
            if (!dn_valid || g_df) begin
                dn_valid = ($urandom_range(0, 2) != 0);
                dn_count = 2'($urandom_range(0, 3));
            end
            load_valid = ($urandom_range(0, 9) == 0);
            load_value = 4'($urandom_range(0, 15));
            step();
        end
        idle_inputs();
        step();
        step();
        chk("rand_feedback", int'(value), m_proj);

        // Checking arms two edges after the first load.
        do_reset();
        load_valid = 1'b1; load_value = 4'd5;
        step();
        idle_inputs();
        corrupt = 4'd1;
        step();
        exp_err = 1;
        step();
        corrupt = '0;
        step();
        step();

        // Asynchronous reset with a command in flight.
        do_reset();
        load_valid = 1'b1; load_value = 4'd7;
        step();
        idle_inputs();
        up_valid = 1'b1; up_count = 2'd2;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_incr_valid", int'(incr_valid), 0);
        chk("async_incr", int'(incr), 0);
        chk("async_proj", int'(proj), 0);
        chk("async_reinit", int'(reinit), 0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_proj  = 0;
        exp_err = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_cmd_packer.md
# counter_cmd_packer

Upstream command stage for the 4-bit up/down `counter`. It accepts increment, decrement and reload requests from independent valid/ready producers. It packs accepted requests into one registered command per cycle on the counter's `incr_valid/incr`, `decr_valid/decr` and `reinit/initial_value` inputs. It keeps a projected count, so the counter never wraps. It also checks the counter's `value` feedback against that projection.

## Interface
Parameters:
- `WIDTH`, 4: counter width. `MAXV` = 2^WIDTH-1.
- `STEP_W`, 2: width of a step. Maximum step is 3.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  reload request.
- `load_value`  in  WIDTH  reload value.
- `load_ready`  out  1  reload accepted when high with `load_valid`.
- `up_valid`  in  1  increment request.
- `up_count`  in  STEP_W  increment amount, 0..3. 0 is legal and is a no-op.
- `up_ready`  out  1  increment accepted when high with `up_valid`.
- `dn_valid`  in  1  decrement request.
- `dn_count`  in  STEP_W  decrement amount.
- `dn_ready`  out  1  decrement accepted when high with `dn_valid`.
- `incr_valid`, `incr[STEP_W]`, `decr_valid`, `decr[STEP_W]`, `reinit`, `initial_value[WIDTH]`  out  command outputs to the counter. All are registered.
- `value`  in  WIDTH  counter's current value (feedback).
- `proj`  out  WIDTH  projected count after all issued commands.
- `mismatch_err`  out  1  sticky flag: `value` disagreed with the projection.

## Operation
- Ready rules. They are combinational from `proj` and the other port's valid, never from a port's own valid:
  - `load_ready = 1`.
  - `dn_ready = !load_valid && (proj >= dn_count)`.
  - `up_ready = !load_valid && (proj + up_count <= MAXV + (dn_fire ? dn_count : 0))`. Compute this with WIDTH+1-bit arithmetic.
- Handshake names: `up_fire = up_valid & up_ready`, `dn_fire = dn_valid & dn_ready`, `load_fire = load_valid & load_ready`.
- Priority:
  - A reload excludes up and down in the same cycle.
  - Up and down may both fire in one cycle. Their net effect is applied together.
- Command register, updated each edge:
  - `incr_valid <= up_fire`, `incr <= up_fire ? up_count : 0`.
  - `decr_valid <= dn_fire`, `decr <= dn_fire ? dn_count : 0`.
  - `reinit <= load_fire`, `initial_value <= load_fire ? load_value : 0`.
  - Every command is a one-cycle pulse. Outputs return to 0 on the next edge unless there is another fire.
- Projection register:
  - `proj <= load_fire ? load_value : proj + (up_fire ? up_count : 0) - (dn_fire ? dn_count : 0)`.
  - By the ready rules, `proj` never leaves 0..MAXV.
- A rejected request stays pending. The producer must hold valid and data stable until ready.
- Feedback check:
  - `proj_d1 <= proj` every edge.
  - Two-stage arm flag: set by the first `load_fire`, and cleared only by reset.
  - When fully armed, set `mismatch_err` on any edge where `value != proj_d1`. It clears only on reset.
- Reset (async assert, sync deassert at the consumer):
  - All command outputs 0, `proj = 0`, `proj_d1 = 0`, arm flags 0, `mismatch_err = 0`.
- Reset mid-operation drops any command in flight. A new load is required to re-arm checking.

## Timing
- Handshake at edge N:
  - The command is visible from N to N+1.
  - The counter applies it at edge N+1.
  - `proj` reflects it right after edge N.
- Throughput: one load, or one up plus one down, per cycle. There are no bubbles.
- Comparison is active from the second edge after the first load handshake. At that point `value` and `proj_d1` are both post-load.

## Structure
- Package `counter_pkg`:
  - `WIDTH` and `STEP_W` defaults.
  - `cnt_t` (logic [WIDTH-1:0]) and `step_t` (logic [STEP_W-1:0]) typedefs.
  - `MAXV` constant.
- Sub-module `counter_bound_check`: combinational. Inputs `proj`, `up_count`, `dn_count`, `dn_valid`, `load_valid`. Outputs `up_ready`, `dn_ready`. It is reused by other credit-style counters.
- Top level: command registers, projection, arm/mismatch logic.

## Test plan
- Reset, then load 5: one cycle later `reinit=1` and `initial_value=5`, `proj=5`. The counter shows 5 at the next edge. `mismatch_err` stays 0.
- `proj=14`, `up_count=3` alone: `up_ready=0` and the request stalls. Add `dn_valid` with `dn_count=2` in the same cycle: both fire, `proj=15`, then `incr=3` and `decr=2` in one cycle.
- `proj=1`, `dn_count=2`: `dn_ready=0`. Then `up_count=1` fires: `proj=2`, and the next cycle `dn` fires to give `proj=0`.
- `load_valid`, `up_valid` and `dn_valid` all asserted: only `load_ready` is high, and `up_ready`/`dn_ready` stay 0.
- After arming, force `value` to differ from `proj_d1` for one cycle: `mismatch_err` rises and stays 1 until reset.
- Assert `rst_n` low while a command is in flight: all outputs go to 0 asynchronously, and `proj=0`.
